fifo_sync: RTL and testbench

Parameterised single-clock FIFO whose storage is a bank of enable-gated data registers with wrapping read/write pointers. It sits directly downstream of producer logic built from the `dff`/`dffr`/`dffre` primitives and decouples a producer that writes on its own schedule from a consumer that reads on its own schedule. Registered occupancy flags, a registered read port and one-cycle error pulses make it safe to place between pipeline stages.

---
 rtl/fifo_sync.sv | 90 +++++++++
 tb/tb_fifo_sync.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO with register-bank storage, count-based full/empty flags,
// a registered read port and one-cycle overflow/underflow pulses.
module fifo_sync #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_unf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [AW:0]      w_cnt_nxt;

  // Acceptance uses the registered flags, so nothing passes through or bypasses.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + (AW+1)'(1);
      2'b01:   w_cnt_nxt = r_cnt - (AW+1)'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Storage is intentionally not reset; a reset edge discards the write.
  always_ff @(posedge clk) begin
    if (r_n && w_wr_acc) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + AW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_MAX);
      r_empty <= (w_cnt_nxt == '0);
      r_ovf   <= wr_en & r_full;
      r_unf   <= rd_en & r_empty;
    end
  end

  assign rd_data   = r_rd_data;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync (DEPTH=4, WIDTH=8) using a queue
// scoreboard of written words and a small occupancy/flag model.
module tb_fifo_sync;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         r_n;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         full;
  logic         empty;
  logic [2:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_sync #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .r_n       (r_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] sb [$];
  int           m_count = 0;
  logic [W-1:0] m_rd  = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  function automatic logic [14:0] obs();
    return {count, full, empty, overflow, underflow, rd_data};
  endfunction

  function automatic logic [14:0] expv();
    return {3'(m_count), (m_count == int'(D)), (m_count == 0), m_ovf, m_unf, m_rd};
  endfunction

  // Drive one cycle of requests, then advance the model past the edge.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    logic wa, ra;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wa = we && (m_count != int'(D));
    ra = re && (m_count != 0);
    @(posedge clk);
    #1;
    if (!r_n) begin
      sb.delete();
      m_count = 0;
      m_rd    = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_ovf = we && (m_count == int'(D));
      m_unf = re && (m_count == 0);
      if (ra) m_rd = sb.pop_front();
      if (wa) sb.push_back(wd);
      m_count = m_count + int'(wa) - int'(ra);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    r_n = 1'b0;
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'hBB, 1'b1);
    total++;
    if (obs() !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", obs(), {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    r_n = 1'b1;
  endtask

  task automatic test_fill_order();
    logic [W-1:0] want [4];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, want[i], 1'b0);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL fill_%0d got=%h want=%h", i, obs(), expv());
      end
    end
    total++;
    if (full !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("FAIL fill_full got full=%b count=%0d want full=1 count=4", full, count);
    end
    step(1'b1, 8'h55, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== 3'd4 || obs() !== expv()) begin
      bad++;
      $display("FAIL overflow_pulse got=%h want=%h", obs(), expv());
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got=%b want=0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++;
      if (rd_data !== want[i] || obs() !== expv()) begin
        bad++;
        $display("FAIL read_order_%0d got=%h want=%h data want=%h", i, obs(), expv(), want[i]);
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty got=%b want=1", empty);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    for (int k = 3; k <= 12; k++) begin
      logic [W-1:0] exp_rd;
      exp_rd = W'(k - 2);
      step(k <= 10, W'(k), 1'b1);
      total++;
      if (rd_data !== exp_rd || count > 3'd2 || obs() !== expv()) begin
        bad++;
        $display("FAIL wrap_%0d got=%h want=%h data want=%h", k, obs(), expv(), exp_rd);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hA0 + i), 1'b0);
    step(1'b1, 8'h66, 1'b1);
    total++;
    if (count !== 3'd3 || overflow !== 1'b1 || rd_data !== 8'hA0 || obs() !== expv()) begin
      bad++;
      $display("FAIL full_both got=%h want=%h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    held = rd_data;
    step(1'b1, 8'h77, 1'b1);
    total++;
    if (count !== 3'd1 || underflow !== 1'b1 || rd_data !== held || obs() !== expv()) begin
      bad++;
      $display("FAIL empty_both got=%h want=%h held=%h", obs(), expv(), held);
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (rd_data !== 8'h77 || obs() !== expv()) begin
      bad++;
      $display("FAIL empty_both_read got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'(8'hC2 + i), 1'b1);
      total++;
      if (count !== 3'd2 || overflow !== 1'b0 || underflow !== 1'b0 ||
          rd_data !== W'(8'hC0 + i) || obs() !== expv()) begin
        bad++;
        $display("FAIL steady_%0d got=%h want=%h", i, obs(), expv());
      end
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (empty !== 1'b1 || rd_data !== 8'hC9 || obs() !== expv()) begin
      bad++;
      $display("FAIL steady_drain got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hE0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (count !== 3'd2 || rd_data !== 8'hE0 || obs() !== expv()) begin
      bad++;
      $display("FAIL pre_reset got=%h want=%h", obs(), expv());
    end
    step(1'b1, 8'hE5, 1'b0);
    r_n = 1'b0;
    step(1'b1, 8'h99, 1'b0);
    r_n = 1'b1;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 8'h00 || obs() !== expv()) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", obs(), expv());
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (underflow !== 1'b1 || obs() !== expv()) begin
      bad++;
      $display("FAIL mid_reset_underflow got=%h want=%h", obs(), expv());
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear got=%b want=0", underflow);
    end
  endtask

  initial begin
    r_n     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    test_reset();
    test_fill_order();
    test_wrap();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
